// File: rtl/bthreadgroup_acc_if.sv
// bthreadgroup_acc_if: beat input and result output bundle for the threadgroup.
// master drives beats/out_ready; slave (the threadgroup) returns in_ready/results.
interface bthreadgroup_acc_if #(
    parameter int LANES = 4,
    parameter int GROUP = 16,
    parameter int NNZ   = 4,
    parameter int ACT_W = 8,
    parameter int WGT_W = 8,
    parameter int OUT_W = 16
);
    localparam int IDXW = $clog2(GROUP);

    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic                        in_mode;
    logic [GROUP*ACT_W-1:0]      in_act;
    logic [LANES*NNZ*WGT_W-1:0]  in_wgt;
    logic [LANES*NNZ*IDXW-1:0]   in_idx;
    logic [LANES*5-1:0]          shift_cfg;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*OUT_W-1:0]      out_data;
    logic [LANES-1:0]            out_sat;

    modport master (
        output in_valid, in_last, in_mode,
        output in_act, in_wgt, in_idx, shift_cfg,
        output out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_last, in_mode,
        input  in_act, in_wgt, in_idx, shift_cfg,
        input  out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/bthreadgroup_acc.sv
// bthreadgroup_acc: LANES sparse dot-product lanes over a broadcast activation
// group, accumulated across a K tile, then rounded/shifted/saturated.
// Ports: clk, rst (async active-low), bus (slave): beat in_* with
// in_valid/in_ready, shift_cfg, results out_data/out_sat with out_valid/out_ready.
module bthreadgroup_acc #(
    parameter int LANES = 4,
    parameter int GROUP = 16,
    parameter int NNZ   = 4,
    parameter int ACT_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    bthreadgroup_acc_if.slave bus
);
    localparam int IDXW = $clog2(GROUP);
    localparam int PW   = ACT_W + WGT_W;
    localparam int RW   = ACC_W + 1;
    localparam logic signed [RW-1:0] MAXV =
        RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] MINV =
        RW'(-(64'sd1 <<< (OUT_W - 1)));

    logic                     en;
    logic                     out_valid_q;
    logic [LANES*OUT_W-1:0]   out_data_q;
    logic [LANES-1:0]         out_sat_q;

    logic signed [ACT_W-1:0]  act [GROUP];
    logic signed [WGT_W-1:0]  wgt [LANES][NNZ];
    logic [IDXW-1:0]          idx [LANES][NNZ];
    logic signed [PW-1:0]     prod [LANES][NNZ];

    logic                     s1_valid;
    logic                     s1_last;
    logic [LANES*5-1:0]       s1_shift;
    logic signed [PW-1:0]     s1_prod [LANES][NNZ];

    logic                     first;
    logic signed [ACC_W-1:0]  acc [LANES];
    logic signed [ACC_W-1:0]  sum [LANES];
    logic signed [ACC_W-1:0]  acc_next [LANES];
    logic signed [RW-1:0]     r [LANES];
    logic [LANES*OUT_W-1:0]   res_data;
    logic [LANES-1:0]         res_sat;

    // A held result freezes the whole pipeline.
    assign en            = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    for (genvar g = 0; g < GROUP; g++) begin : g_act
        assign act[g] = bus.in_act[g*ACT_W +: ACT_W];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar n = 0; n < NNZ; n++) begin : g_nz
            assign wgt[l][n] = bus.in_wgt[(l*NNZ+n)*WGT_W +: WGT_W];
            assign idx[l][n] = bus.in_idx[(l*NNZ+n)*IDXW +: IDXW];
        end
    end

    // Round-half-up then arithmetic shift, one bit wider so the
    // rounding increment cannot overflow.
    function automatic logic signed [RW-1:0] rnd_shift(
        input logic signed [ACC_W-1:0] a,
        input logic [4:0]              sh
    );
        logic signed [RW-1:0] w;
        logic signed [RW-1:0] half;
        w = RW'(a);
        if (sh == 5'd0) return w;
        half = RW'(1) << (sh - 5'd1);
        w = w + half;
        return w >>> sh;
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int n = 0; n < NNZ; n++) begin
                prod[l][n] = '0;
                if (!(bus.in_mode && n >= NNZ/2))
                    prod[l][n] = act[idx[l][n]] * wgt[l][n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
            for (int l = 0; l < LANES; l++)
                for (int n = 0; n < NNZ; n++)
                    s1_prod[l][n] <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_valid && bus.in_last;
            s1_shift <= bus.shift_cfg;
            for (int l = 0; l < LANES; l++)
                for (int n = 0; n < NNZ; n++)
                    s1_prod[l][n] <= prod[l][n];
        end
    end

    always_comb begin
        res_data = '0;
        res_sat  = '0;
        for (int l = 0; l < LANES; l++) begin
            sum[l] = '0;
            for (int n = 0; n < NNZ; n++)
                sum[l] = sum[l] + ACC_W'(s1_prod[l][n]);
            acc_next[l] = (first ? '0 : acc[l]) + sum[l];
            r[l] = rnd_shift(acc_next[l], s1_shift[l*5 +: 5]);
            if (r[l] > MAXV) begin
                res_data[l*OUT_W +: OUT_W] = MAXV[OUT_W-1:0];
                res_sat[l] = 1'b1;
            end else if (r[l] < MINV) begin
                res_data[l*OUT_W +: OUT_W] = MINV[OUT_W-1:0];
                res_sat[l] = 1'b1;
            end else begin
                res_data[l*OUT_W +: OUT_W] = r[l][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < LANES; l++)
                acc[l] <= '0;
            first       <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else if (en) begin
            if (s1_valid) begin
                for (int l = 0; l < LANES; l++)
                    acc[l] <= acc_next[l];
                first <= s1_last;
            end
            // Load wins over drain, so a result can replace the
            // one being consumed without a bubble.
            if (s1_valid && s1_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_data;
                out_sat_q   <= res_sat;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bthreadgroup_acc.sv
// tb_bthreadgroup_acc: directed and random beats against a tile-level
// arithmetic model of the accumulating threadgroup.
module tb_bthreadgroup_acc;
    localparam int LANES = 4;
    localparam int GROUP = 16;
    localparam int NNZ   = 4;
    localparam int OUT_W = 16;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  sat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bthreadgroup_acc_if #(
        .LANES(LANES), .GROUP(GROUP), .NNZ(NNZ),
        .ACT_W(8), .WGT_W(8), .OUT_W(OUT_W)
    ) bus ();

    bthreadgroup_acc #(
        .LANES(LANES), .GROUP(GROUP), .NNZ(NNZ),
        .ACT_W(8), .WGT_W(8), .ACC_W(32), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    res_t q[$];

    int b_act [GROUP];
    int b_wgt [LANES][NNZ];
    int b_idx [LANES][NNZ];
    int b_sh  [LANES];
    bit b_mode, b_last;

    longint macc [LANES];
    bit mfirst = 1'b1;

    bit accepted, hold_prev, rnd_ready;
    logic [63:0] prev_data;
    logic [3:0]  prev_sat;
    int stall_cnt = 0;
    int cyc = 0;

    task automatic chk(string tag, logic signed [63:0] obs,
                       logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Tile-level reference: dot product per beat, 32-bit wrapping
    // accumulation, final rounding and clipping on plain integers.
    task automatic model_accept();
        longint dot, rr;
        res_t e;
        e.data = '0;
        e.sat  = '0;
        for (int l = 0; l < LANES; l++) begin
            dot = 0;
            for (int n = 0; n < NNZ; n++)
                if (!(b_mode && n >= NNZ/2))
                    dot += longint'(b_act[b_idx[l][n]]) * b_wgt[l][n];
            if (mfirst) macc[l] = 0;
            macc[l] = longint'(int'(macc[l] + dot));
            if (b_last) begin
                if (b_sh[l] == 0) rr = macc[l];
                else rr = (macc[l] + (longint'(1) << (b_sh[l] - 1)))
                          >>> b_sh[l];
                if (rr > 32767) begin
                    rr = 32767; e.sat[l] = 1'b1;
                end else if (rr < -32768) begin
                    rr = -32768; e.sat[l] = 1'b1;
                end
                e.data[l*16 +: 16] = rr[15:0];
            end
        end
        if (b_last) q.push_back(e);
        mfirst = b_last;
    endtask

    task automatic drive();
        bus.in_valid = 1'b1;
        bus.in_last  = b_last;
        bus.in_mode  = b_mode;
        for (int g = 0; g < GROUP; g++)
            bus.in_act[g*8 +: 8] = b_act[g][7:0];
        for (int l = 0; l < LANES; l++) begin
            bus.shift_cfg[l*5 +: 5] = b_sh[l][4:0];
            for (int n = 0; n < NNZ; n++) begin
                bus.in_wgt[(l*NNZ+n)*8 +: 8] = b_wgt[l][n][7:0];
                bus.in_idx[(l*NNZ+n)*4 +: 4] = b_idx[l][n][3:0];
            end
        end
    endtask

    task automatic cycle();
        res_t e;
        @(negedge clk);
        chk("in_ready_rule", bus.in_ready,
            !(bus.out_valid && !bus.out_ready));
        if (hold_prev) begin
            chk("hold_data", bus.out_data, prev_data);
            chk("hold_sat", bus.out_sat, prev_sat);
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        prev_sat  = bus.out_sat;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL spurious_result obs=%0h exp=none",
                       bus.out_data);
            end else begin
                e = q.pop_front();
                chk("result_data", bus.out_data, e.data);
                chk("result_sat", bus.out_sat, e.sat);
            end
        end
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) model_accept();
        @(posedge clk);
        #1;
        cyc++;
        if (stall_cnt > 0) begin
            stall_cnt--;
            bus.out_ready = 1'b0;
        end else begin
            bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send_beat(string tag);
        drive();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (accepted) break;
        end
        chk({tag, "_accept"}, accepted, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(string tag, int lane0, logic [3:0] sat);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk({tag, "_valid"}, found, 1);
        if (found) begin
            chk({tag, "_lane0"}, signed'(bus.out_data[15:0]), lane0);
            chk({tag, "_sat"}, bus.out_sat, sat);
        end
    endtask

    task automatic plan_beat();
        for (int g = 0; g < GROUP; g++) b_act[g] = g + 1;
        for (int l = 0; l < LANES; l++) begin
            b_sh[l] = 0;
            for (int n = 0; n < NNZ; n++) begin
                b_wgt[l][n] = 0;
                b_idx[l][n] = 0;
            end
        end
        for (int n = 0; n < NNZ; n++) begin
            b_wgt[0][n] = 1;
            b_idx[0][n] = n;
        end
        b_mode = 1'b0;
        b_last = 1'b0;
    endtask

    task automatic rand_beat();
        for (int g = 0; g < GROUP; g++)
            b_act[g] = int'($urandom_range(0, 255)) - 128;
        for (int l = 0; l < LANES; l++) begin
            b_sh[l] = int'($urandom_range(0, 31));
            for (int n = 0; n < NNZ; n++) begin
                b_wgt[l][n] = int'($urandom_range(0, 255)) - 128;
                b_idx[l][n] = int'($urandom_range(0, GROUP - 1));
            end
        end
        b_mode = 1'($urandom_range(0, 1));
        b_last = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int start;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        bus.in_idx    = '0;
        bus.shift_cfg = '0;
        bus.out_ready = 1'b1;
        rnd_ready     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // single beat, two-edge latency
        plan_beat();
        b_last = 1'b1;
        drive();
        cycle();
        bus.in_valid = 1'b0;
        chk("lat_e0_valid", bus.out_valid, 0);
        cycle();
        chk("lat_e1_valid", bus.out_valid, 1);
        chk("lat_e1_lane0", signed'(bus.out_data[15:0]), 10);
        chk("lat_e1_sat", bus.out_sat, 0);

        // 3-beat tile then immediate 1-beat tile, 1 beat/cycle
        cycle();
        start = cyc;
        plan_beat();
        send_beat("t3b0");
        send_beat("t3b1");
        b_last = 1'b1;
        send_beat("t3b2");
        send_beat("t1b0");
        chk("throughput", cyc - start, 4);
        wait_result("tile3", 30, 4'b0000);
        cycle();
        wait_result("tile1_after", 10, 4'b0000);

        // half mode, then lane1 gather
        plan_beat();
        b_last = 1'b1;
        b_mode = 1'b1;
        b_idx[1][0] = 15; b_idx[1][1] = 15;
        b_wgt[1][0] = -1; b_wgt[1][1] = 2;
        b_wgt[1][2] = 3;  b_wgt[1][3] = 4;
        send_beat("half");
        wait_result("half", 3, 4'b0000);
        b_mode = 1'b0;
        send_beat("lane1");
        wait_result("lane1", 10, 4'b0000);
        chk("lane1_val", signed'(bus.out_data[31:16]), 23);

        // rounding
        plan_beat();
        b_sh[0] = 2;
        send_beat("rp0");
        send_beat("rp1");
        b_last = 1'b1;
        send_beat("rp2");
        wait_result("round_p30", 8, 4'b0000);
        for (int n = 0; n < NNZ; n++) b_wgt[0][n] = -1;
        b_last = 1'b0;
        send_beat("rn0");
        send_beat("rn1");
        b_last = 1'b1;
        send_beat("rn2");
        wait_result("round_n30", -7, 4'b0000);
        plan_beat();
        b_sh[0] = 1;
        b_wgt[0][0] = 1; b_wgt[0][1] = 0;
        b_wgt[0][2] = 0; b_wgt[0][3] = 0;
        b_idx[0][0] = 4;
        b_last = 1'b1;
        send_beat("r5");
        wait_result("round_5", 3, 4'b0000);

        // saturation
        plan_beat();
        b_last = 1'b1;
        for (int g = 0; g < GROUP; g++) b_act[g] = 127;
        for (int n = 0; n < NNZ; n++) b_wgt[0][n] = 127;
        send_beat("satp");
        wait_result("sat_pos", 32767, 4'b0001);
        for (int g = 0; g < GROUP; g++) b_act[g] = -128;
        send_beat("satn");
        wait_result("sat_neg", -32768, 4'b0001);

        // backpressure with the next tiles streaming
        plan_beat();
        b_last = 1'b1;
        send_beat("bp0");
        wait_result("bp_first", 10, 4'b0000);
        bus.out_ready = 1'b0;
        stall_cnt = 4;
        #1;
        chk("bp_in_ready", bus.in_ready, 0);
        b_last = 1'b0;
        send_beat("bp1");
        send_beat("bp2");
        b_last = 1'b1;
        send_beat("bp3");
        b_sh[0] = 1;
        send_beat("bp4");
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        chk("bp_drained", q.size(), 0);

        // reset in the middle of a tile
        plan_beat();
        send_beat("mr0");
        send_beat("mr1");
        rst = 1'b0;
        #1;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_out_data", bus.out_data, 0);
        chk("mr_out_sat", bus.out_sat, 0);
        mfirst = 1'b1;
        q.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_in_ready", bus.in_ready, 1);
        b_last = 1'b1;
        send_beat("mr2");
        wait_result("post_rst", 10, 4'b0000);

        // random beats, idle gaps and random output stalls
        rnd_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) cycle();
            rand_beat();
            if (i == 79) b_last = 1'b1;
            send_beat("rnd");
        end
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() > 0; i++) cycle();
        chk("rnd_drained", q.size(), 0);
        cycle();
        chk("final_idle", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bthreadgroup_acc.md
Name: bthreadgroup_acc

Overview:
Parametrised, pipelined sparse threadgroup. LANES independent sparse dot-product lanes share one broadcast activation group. Each lane gathers NNZ activations by per-weight index, multiplies them by signed weights and reduces the products. Lanes accumulate over a multi-beat K tile delimited by in_last, then emit a rounded, shifted, saturated result through a valid/ready output stage. It replaces the fixed 4-lane, non-accumulating threadgroup in the PE array.

Parameters:
LANES, 4, number of dot-product lanes
GROUP, 16, activations per beat; power of 2; IDXW = log2(GROUP)
NNZ, 4, nonzero weights per lane per beat; even
ACT_W, 8, signed activation width
WGT_W, 8, signed weight width
ACC_W, 32, accumulator width
OUT_W, 16, signed output width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready at a clk edge
in_last  in  1  final beat of the K tile
in_mode  in  1  0 = all NNZ products used; 1 = half mode, products NNZ/2..NNZ-1 forced to 0
in_act  in  GROUP*ACT_W  activation group; element g at [g*ACT_W +: ACT_W]
in_wgt  in  LANES*NNZ*WGT_W  weight (l,n) at [(l*NNZ+n)*WGT_W +: WGT_W]
in_idx  in  LANES*NNZ*IDXW  gather index (l,n); selects in_act element
shift_cfg  in  LANES*5  per-lane right shift 0..31; sampled with the last beat
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  LANES*OUT_W  lane l at [l*OUT_W +: OUT_W]
out_sat  out  LANES  lane result was clipped

Behaviour:
- Reset (rst=0, async): all pipeline registers, accumulators, out_data and out_sat = 0; out_valid = 0; the first-beat flag is set. Reset mid-tile discards the partial tile. in_ready = 1 the cycle after release.
- Global enable en = !(out_valid && !out_ready); in_ready = en. When en = 0, no register changes (full pipeline stall). out_data and out_sat stay stable while out_valid && !out_ready.
- Stage S1 (edge of acceptance):
  - prod[l][n] = signed(in_act[in_idx[l][n]]) * signed(in_wgt[l][n]), ACT_W+WGT_W bits; forced to 0 if in_mode = 1 and n >= NNZ/2.
  - Registered together with valid, last and shift_cfg.
  - A bubble (no acceptance while en = 1) sets S1 valid = 0.
- Stage S2 (next enabled edge, S1 valid):
  - sum[l] = sign-extended sum of the NNZ products.
  - acc_next = (first ? 0 : acc) + sum, wrapping mod 2^ACC_W.
  - acc <= acc_next; first <= S1.last.
- On the S2 edge with last = 1, per lane:
  - r = (sh == 0) ? acc_next : (acc_next + 2^(sh-1)) >>> sh (round-half-up, arithmetic shift).
  - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat[l] = clipped.
  - Load out_data and out_sat; out_valid <= 1.
- Latency: the last beat accepted at edge E gives out_valid = 1 after E+1 (2 enabled edges, no stalls). Throughput is 1 beat/cycle.
- out_valid clears on the handshake edge unless a new result loads on the same edge; simultaneous drain and load is allowed with no bubble.
- Back-to-back tiles: a beat following a last beat starts a new accumulation. A 1-beat tile with in_last = 1 is legal.
- Empty input (in_valid = 0) never changes acc.

Test Plan:
- Single beat, in_act[g] = g+1, lane0 wgt {1,1,1,1} idx {0,1,2,3}, in_last=1, shift 0 -> out_valid 2 cycles later, lane0 = 10, out_sat = 0.
- 3-beat tile of the same beat, last on beat 3 -> lane0 = 30. An immediate second 1-beat tile -> lane0 = 10, so acc was cleared.
- in_mode=1, same beat -> lane0 = 1+2 = 3. Lane1 idx {15,15,0,0} wgt {-1,2,3,4}, mode 0 -> 16+3+4 = 23.
- Rounding: acc 30, shift 2 -> 8; acc -30, shift 2 -> -7; acc 5, shift 1 -> 3.
- Saturation: act 127, wgt 127 on all 4 -> 64516 -> 32767, sat=1. Act -128, wgt 127 -> -65024 -> -32768, sat=1.
- Backpressure: out_ready=0 for 5 cycles with the next tile streaming -> in_ready=0, out_data stable, no beats lost. After release, results match. Reset asserted mid-tile -> out_valid=0, and the next tile's result carries no residue.
